// File: rtl/jtag_tap_cfg.sv
// IEEE 1149.1 TAP with IDCODE, STATUS, BYPASS and a PROGRAM register that
// streams CFG_WIDTH-bit configuration words straight out of Shift-DR.
module jtag_tap_cfg #(
   parameter int          IR_LEN    = 4,
   parameter int          CFG_WIDTH = 32,
   parameter logic [31:0] IDCODE    = 32'h1000_0001,
   parameter int          CNT_W     = 16
) (
   input  logic                 tck,
   input  logic                 trst,
   input  logic                 tms,
   input  logic                 tdi,
   output logic                 tdo,
   output logic [CFG_WIDTH-1:0] config_data,
   output logic                 config_strobe,
   output logic                 active,
   output logic [CNT_W-1:0]     word_count
);

   localparam int BC_W = $clog2(CFG_WIDTH);
   localparam logic [IR_LEN-1:0] OP_IDCODE  = IR_LEN'(1);
   localparam logic [IR_LEN-1:0] OP_PROGRAM = IR_LEN'(2);
   localparam logic [IR_LEN-1:0] OP_STATUS  = IR_LEN'(3);
   localparam logic [BC_W-1:0]   LAST_BIT   = BC_W'(CFG_WIDTH - 1);

   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
      SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
   } tap_state_t;

   typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_PROGRAM, DR_STATUS} dr_sel_t;

   tap_state_t           state_reg;
   logic [IR_LEN-1:0]    ir_reg;
   logic [IR_LEN-1:0]    ir_sh_reg;
   logic                 bypass_reg;
   logic [31:0]          idcode_sh_reg;
   logic [31:0]          status_sh_reg;
   logic [CFG_WIDTH-1:0] prog_sh_reg;
   logic [BC_W-1:0]      bit_cnt_reg;
   logic                 partial_reg;
   logic [CNT_W-1:0]     word_count_reg;
   logic [CFG_WIDTH-1:0] config_data_reg;
   logic                 config_strobe_reg;
   dr_sel_t              dr_sel;

   // Unassigned opcodes fall through to BYPASS.
   always_comb begin
      dr_sel = DR_BYPASS;
      if (ir_reg == OP_IDCODE)       dr_sel = DR_IDCODE;
      else if (ir_reg == OP_PROGRAM) dr_sel = DR_PROGRAM;
      else if (ir_reg == OP_STATUS)  dr_sel = DR_STATUS;
   end

   always_comb begin
      tdo = 1'b0;
      if (state_reg == SHIFT_IR) begin
         tdo = ir_sh_reg[0];
      end else if (state_reg == SHIFT_DR) begin
         case (dr_sel)
            DR_IDCODE:  tdo = idcode_sh_reg[0];
            DR_PROGRAM: tdo = prog_sh_reg[0];
            DR_STATUS:  tdo = status_sh_reg[0];
            default:    tdo = bypass_reg;
         endcase
      end
   end

   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         state_reg         <= TLR;
         ir_reg            <= OP_IDCODE;
         ir_sh_reg         <= '0;
         bypass_reg        <= 1'b0;
         idcode_sh_reg     <= '0;
         status_sh_reg     <= '0;
         prog_sh_reg       <= '0;
         bit_cnt_reg       <= '0;
         partial_reg       <= 1'b0;
         word_count_reg    <= '0;
         config_data_reg   <= '0;
         config_strobe_reg <= 1'b0;
      end else if (tms && (state_reg == TLR || state_reg == SEL_IR)) begin
         // Entering Test-Logic-Reset by tms: like trst, but the word count and partial flag survive.
         state_reg         <= TLR;
         ir_reg            <= OP_IDCODE;
         ir_sh_reg         <= '0;
         bypass_reg        <= 1'b0;
         idcode_sh_reg     <= '0;
         status_sh_reg     <= '0;
         prog_sh_reg       <= '0;
         bit_cnt_reg       <= '0;
         config_data_reg   <= '0;
         config_strobe_reg <= 1'b0;
      end else begin
         config_strobe_reg <= 1'b0;
         case (state_reg)
            TLR:      state_reg <= RTI;
            RTI:      state_reg <= tms ? SEL_DR : RTI;
            SEL_DR:   state_reg <= tms ? SEL_IR : CAP_DR;
            CAP_DR: begin
               state_reg <= tms ? EXIT1_DR : SHIFT_DR;
               case (dr_sel)
                  DR_IDCODE:  idcode_sh_reg <= IDCODE;
                  DR_PROGRAM: bit_cnt_reg   <= '0;
                  DR_STATUS:  status_sh_reg <= {15'b0, partial_reg, 16'(word_count_reg)};
                  default:    bypass_reg    <= 1'b0;
               endcase
            end
            SHIFT_DR: begin
               state_reg <= tms ? EXIT1_DR : SHIFT_DR;
               case (dr_sel)
                  DR_IDCODE: idcode_sh_reg <= {tdi, idcode_sh_reg[31:1]};
                  DR_STATUS: status_sh_reg <= {tdi, status_sh_reg[31:1]};
                  DR_PROGRAM: begin
                     prog_sh_reg <= {tdi, prog_sh_reg[CFG_WIDTH-1:1]};
                     if (bit_cnt_reg == LAST_BIT) begin
                        config_data_reg   <= {tdi, prog_sh_reg[CFG_WIDTH-1:1]};
                        config_strobe_reg <= 1'b1;
                        bit_cnt_reg       <= '0;
                        if (word_count_reg != '1) word_count_reg <= word_count_reg + 1'b1;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end
                  default:   bypass_reg <= tdi;
               endcase
            end
            EXIT1_DR: state_reg <= tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_reg <= tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_reg <= tms ? UPD_DR : SHIFT_DR;
            UPD_DR: begin
               state_reg <= tms ? SEL_DR : RTI;
               if (dr_sel == DR_PROGRAM) begin
                  partial_reg <= (bit_cnt_reg != '0);
                  bit_cnt_reg <= '0;
               end
            end
            SEL_IR:   state_reg <= CAP_IR;
            CAP_IR: begin
               state_reg <= tms ? EXIT1_IR : SHIFT_IR;
               ir_sh_reg <= IR_LEN'(1);
            end
            SHIFT_IR: begin
               state_reg <= tms ? EXIT1_IR : SHIFT_IR;
               ir_sh_reg <= {tdi, ir_sh_reg[IR_LEN-1:1]};
            end
            EXIT1_IR: state_reg <= tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_reg <= tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_reg <= tms ? UPD_IR : SHIFT_IR;
            UPD_IR: begin
               state_reg <= tms ? SEL_DR : RTI;
               ir_reg    <= ir_sh_reg;
            end
            default:  state_reg <= TLR;
         endcase
      end
   end

   assign active = (dr_sel == DR_PROGRAM) &&
                   (state_reg inside {CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR});
   assign config_data   = config_data_reg;
   assign config_strobe = config_strobe_reg;
   assign word_count    = word_count_reg;

endmodule
